// File: rtl/encoder8_3_req.sv
// Registered 8-to-3 request encoder: collects request bits, presents one index at a time.
// Latency: request sampled at edge k is pending after k, presented (y_valid=1) after k+1.
// Backpressure: y/y_valid held stable while y_ready=0; one index per cycle while y_ready=1.
//
// Ports:
//   clk, rst_n        rising-edge clock, asynchronous active-low reset
//   en                capture enable for the request vector i
//   i[N-1:0]          request vector, any number of bits may be set
//   y[W-1:0]          index currently presented, valid when y_valid=1
//   y_valid, y_ready  valid/ready handshake on y
//   pend[N-1:0]       registered pending-request vector
//   ovf               one-cycle pulse: request arrived for a bit already pending
//
// Build option: define ENC_ROUND_ROBIN_EN for round-robin selection starting after the
// last accepted index; otherwise fixed priority with the highest index winning.
module encoder8_3_req #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [N-1:0] i,
    output logic [W-1:0] y,
    output logic         y_valid,
    input  logic         y_ready,
    output logic [N-1:0] pend,
    output logic         ovf
);

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    state_t       r_state;
    state_t       w_state_nxt;
    logic [W-1:0] r_y;
    logic [W-1:0] w_y_nxt;
    logic [N-1:0] r_pend;
    logic [N-1:0] w_pend_nxt;
    logic         r_ovf;
    logic         w_ovf_nxt;
    logic         w_xfer;
    logic [N-1:0] w_clr;
    logic [N-1:0] w_remain;
    logic [N-1:0] w_sel_vec;
    logic [W-1:0] w_pick;

`ifdef ENC_ROUND_ROBIN_EN
    logic [W-1:0] r_ptr;
    logic [W-1:0] w_sel_last;

    // First set bit searching upward from last+1, wrapping; last itself is checked last.
    function automatic logic [W-1:0] f_pick_rr(input logic [N-1:0] v, input logic [W-1:0] last);
        logic [W-1:0] r;
        logic [W-1:0] idx;
        logic         found;
        r     = '0;
        found = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx = last + W'(k);
            if (!found && v[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction
`else
    // Highest set bit wins.
    function automatic logic [W-1:0] f_pick_hi(input logic [N-1:0] v);
        logic [W-1:0] r;
        r = '0;
        for (int k = 0; k < N; k++) begin
            if (v[k]) begin
                r = W'(k);
            end
        end
        return r;
    endfunction
`endif

    assign w_xfer = (r_state == ST_PRESENT) && y_ready;

    always_comb begin
        w_clr = '0;
        if (w_xfer) begin
            w_clr[r_y] = 1'b1;
        end
    end

    assign w_remain = r_pend & ~w_clr;

    // A fresh request on the bit being cleared re-sets it (OR after the clear).
    assign w_pend_nxt = en ? (w_remain | i) : w_remain;
    assign w_ovf_nxt  = en && (|(i & w_remain));

    // Selection only looks at registered state: in PRESENT the just-accepted bit is excluded,
    // so same-edge arrivals never get presented before they are registered.
    assign w_sel_vec = (r_state == ST_PRESENT) ? w_remain : r_pend;

`ifdef ENC_ROUND_ROBIN_EN
    // During a transfer the accepted index becomes the new pointer, so search after it.
    assign w_sel_last = (r_state == ST_PRESENT) ? r_y : r_ptr;
    assign w_pick     = f_pick_rr(w_sel_vec, w_sel_last);
`else
    assign w_pick = f_pick_hi(w_sel_vec);
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_y_nxt     = r_y;
        case (r_state)
            ST_IDLE: begin
                if (|r_pend) begin
                    w_y_nxt     = w_pick;
                    w_state_nxt = ST_PRESENT;
                end
            end
            ST_PRESENT: begin
                if (y_ready) begin
                    if (|w_remain) begin
                        w_y_nxt = w_pick;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_y     <= '0;
            r_pend  <= '0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_y     <= w_y_nxt;
            r_pend  <= w_pend_nxt;
            r_ovf   <= w_ovf_nxt;
        end
    end

`ifdef ENC_ROUND_ROBIN_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= W'(N - 1);
        end else if (w_xfer) begin
            r_ptr <= r_y;
        end
    end
`endif

    assign y       = r_y;
    assign y_valid = (r_state == ST_PRESENT);
    assign pend    = r_pend;
    assign ovf     = r_ovf;

endmodule

// File: tb/tb_encoder8_3_req.sv
module tb_encoder8_3_req;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic [7:0] i;
    logic [2:0] y;
    logic       y_valid;
    logic       y_ready;
    logic [7:0] pend;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [7:0] m_pend;
    logic [2:0] m_y;
    logic       m_valid;
    logic       m_ovf;
    int         m_ptr;

    encoder8_3_req dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .en      (en),
        .i       (i),
        .y       (y),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .pend    (pend),
        .ovf     (ovf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic model_reset();
        m_pend  = 8'h00;
        m_y     = 3'd0;
        m_valid = 1'b0;
        m_ovf   = 1'b0;
        m_ptr   = 7;
    endtask

    // Choose the next index out of a set of pending requests.
    function automatic int model_pick(input logic [7:0] v, input int after);
        int res;
        res = -1;
`ifdef ENC_ROUND_ROBIN_EN
        for (int k = 1; k <= 8; k++) begin
            if (res < 0 && v[(after + k) % 8]) res = (after + k) % 8;
        end
`else
        for (int b = 7; b >= 0; b--) begin
            if (res < 0 && v[b] && after >= 0) res = b;
        end
`endif
        return res;
    endfunction

    // One clock edge: update the model from the inputs present at the edge.
    task automatic tick();
        logic [7:0] keep;
        logic       xfer;
        int         nxt;
        @(posedge clk);
        if (rst_n) begin
            xfer = m_valid && y_ready;
            keep = m_pend;
            if (xfer) keep[m_y] = 1'b0;
            m_ovf  = en && ((i & keep) != 8'h00);
            if (!m_valid) begin
                if (m_pend != 8'h00) begin
                    m_y     = 3'(model_pick(m_pend, m_ptr));
                    m_valid = 1'b1;
                end
            end else if (xfer) begin
                m_ptr = int'(m_y);
                if (keep != 8'h00) begin
                    nxt = model_pick(keep, m_ptr);
                    m_y = 3'(nxt);
                end else begin
                    m_valid = 1'b0;
                end
            end
            m_pend = en ? (keep | i) : keep;
        end
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; i = 8'h00; y_ready = 1'b0;
        model_reset();
        #1;
        total++;
        if ({y_valid, y, pend, ovf} !== 13'h0) begin
            bad++;
            $display("FAIL reset_state got v=%b y=%0d pend=%h ovf=%b want all 0", y_valid, y, pend, ovf);
        end
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if ({y_valid, pend, ovf} !== 10'h0) begin
            bad++;
            $display("FAIL reset_release got v=%b pend=%h ovf=%b want 0", y_valid, pend, ovf);
        end
    endtask

    task automatic test_single();
        en = 1'b1; i = 8'h08; y_ready = 1'b0;
        tick();
        i = 8'h00;
        total++;
        if (pend !== 8'h08 || y_valid !== 1'b0) begin
            bad++;
            $display("FAIL single_capture got pend=%h v=%b want pend=08 v=0", pend, y_valid);
        end
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (y_valid !== 1'b1 || y !== 3'd3) begin
                bad++;
                $display("FAIL single_hold c=%0d got v=%b y=%0d want v=1 y=3", c, y_valid, y);
            end
        end
        y_ready = 1'b1;
        tick();
        total++;
        if (y_valid !== 1'b0 || pend !== 8'h00) begin
            bad++;
            $display("FAIL single_drain got v=%b pend=%h want v=0 pend=00", y_valid, pend);
        end
    endtask

    task automatic test_burst(input logic [7:0] req, input int n, input int exp_seq[8]);
        en = 1'b1; i = req; y_ready = 1'b1;
        tick();
        i = 8'h00;
        total++;
        if (pend !== req) begin
            bad++;
            $display("FAIL burst_capture got pend=%h want %h", pend, req);
        end
        for (int k = 0; k < n; k++) begin
            tick();
            total++;
            if (y_valid !== 1'b1 || int'(y) != exp_seq[k]) begin
                bad++;
                $display("FAIL burst_seq req=%h k=%0d got v=%b y=%0d want v=1 y=%0d", req, k, y_valid, y, exp_seq[k]);
            end
        end
        tick();
        total++;
        if (y_valid !== 1'b0 || pend !== 8'h00) begin
            bad++;
            $display("FAIL burst_drain req=%h got v=%b pend=%h want v=0 pend=00", req, y_valid, pend);
        end
    endtask

    task automatic test_en_off();
        en = 1'b0; i = 8'hFF; y_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            total++;
            if (pend !== 8'h00 || y_valid !== 1'b0 || ovf !== 1'b0) begin
                bad++;
                $display("FAIL en_off c=%0d got pend=%h v=%b ovf=%b want 00/0/0", c, pend, y_valid, ovf);
            end
        end
        en = 1'b1; i = 8'h00;
    endtask

    task automatic test_rearm();
        en = 1'b1; i = 8'h08; y_ready = 1'b0;
        tick();
        i = 8'h00;
        tick();
        total++;
        if (y_valid !== 1'b1 || y !== 3'd3) begin
            bad++;
            $display("FAIL rearm_present got v=%b y=%0d want v=1 y=3", y_valid, y);
        end
        i = 8'h08; y_ready = 1'b1;
        tick();
        total++;
        if (pend !== 8'h08 || ovf !== 1'b0 || y_valid !== 1'b0) begin
            bad++;
            $display("FAIL rearm_same_edge got pend=%h ovf=%b v=%b want 08/0/0", pend, ovf, y_valid);
        end
        i = 8'h00; y_ready = 1'b0;
        tick();
        total++;
        if (y_valid !== 1'b1 || y !== 3'd3 || ovf !== 1'b0) begin
            bad++;
            $display("FAIL rearm_again got v=%b y=%0d ovf=%b want 1/3/0", y_valid, y, ovf);
        end
        i = 8'h08;
        tick();
        i = 8'h00;
        total++;
        if (ovf !== 1'b1) begin
            bad++;
            $display("FAIL ovf_pulse got %b want 1", ovf);
        end
        tick();
        total++;
        if (ovf !== 1'b0 || y_valid !== 1'b1 || y !== 3'd3) begin
            bad++;
            $display("FAIL ovf_one_cycle got ovf=%b v=%b y=%0d want 0/1/3", ovf, y_valid, y);
        end
        y_ready = 1'b1;
        tick();
        total++;
        if (y_valid !== 1'b0 || pend !== 8'h00) begin
            bad++;
            $display("FAIL rearm_drain got v=%b pend=%h want 0/00", y_valid, pend);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            en      = ($urandom_range(0, 3) != 0);
            i       = 8'($urandom & $urandom & $urandom);
            y_ready = ($urandom_range(0, 2) != 0);
            tick();
            total++;
            if ({y_valid, (y_valid ? y : 3'd0), pend, ovf} !== {m_valid, (m_valid ? m_y : 3'd0), m_pend, m_ovf}) begin
                bad++;
                $display("FAIL random c=%0d got v=%b y=%0d pend=%h ovf=%b want v=%b y=%0d pend=%h ovf=%b",
                         c, y_valid, y, pend, ovf, m_valid, m_y, m_pend, m_ovf);
            end
        end
        en = 1'b1; i = 8'h00; y_ready = 1'b1;
        for (int c = 0; c < 10; c++) tick();
        total++;
        if (y_valid !== 1'b0 || pend !== 8'h00) begin
            bad++;
            $display("FAIL random_drain got v=%b pend=%h want 0/00", y_valid, pend);
        end
    endtask

    task automatic test_async_reset();
        en = 1'b1; i = 8'h42; y_ready = 1'b0;
        tick();
        i = 8'h00;
        tick();
        total++;
        if (y_valid !== 1'b1 || pend !== 8'h42) begin
            bad++;
            $display("FAIL areset_setup got v=%b pend=%h want 1/42", y_valid, pend);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({y_valid, y, pend, ovf} !== 13'h0) begin
            bad++;
            $display("FAIL areset_immediate got v=%b y=%0d pend=%h ovf=%b want all 0", y_valid, y, pend, ovf);
        end
        model_reset();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        total++;
        if (y_valid !== 1'b0 || pend !== 8'h00) begin
            bad++;
            $display("FAIL areset_after got v=%b pend=%h want 0/00", y_valid, pend);
        end
    endtask

    initial begin
        int seq_a5[8];
        int seq_81[8];
`ifdef ENC_ROUND_ROBIN_EN
        seq_a5 = '{0, 2, 5, 7, 0, 0, 0, 0};
        seq_81 = '{0, 7, 0, 0, 0, 0, 0, 0};
`else
        seq_a5 = '{7, 5, 2, 0, 0, 0, 0, 0};
        seq_81 = '{7, 0, 0, 0, 0, 0, 0, 0};
`endif
        test_reset();
        test_single();
        test_burst(8'hA5, 4, seq_a5);
        test_burst(8'h81, 2, seq_81);
        test_en_off();
        test_rearm();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
